crc16_rx_check: RTL and testbench

Receive-side CRC16 checker for the USB controller's DATA-packet path. It consumes the serial, already NRZI-decoded and bit-unstuffed bit stream from the receive bit-unstuffer. It reassembles the packet (PID, payload, CRC16) into a parallel register, checks the USB CRC16 residual and the PID check nibble, and hands the packet plus status to the protocol handler under a hold-until-ack handshake. It is the inverse of the transmit CRC16 calculator: a frame that calculator emits must pass this check.

---
 rtl/crc16_rx_check.sv | 128 ++++++++++++
 tb/tb_crc16_rx_check.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_rx_check.sv
// Receive-side USB CRC16 checker: reassembles an unstuffed DATA packet (PID,
// payload, CRC16) and holds residual/PID/length status until the handler acks.
module crc16_rx_check (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         rx_start,
  input  logic         bit_valid,
  input  logic         bit_in,
  input  logic         rx_eop,
  input  logic         rx_abort,
  input  logic         ph_ack,
  output logic [99:0]  pkt_out,
  output logic [6:0]   pkt_len,
  output logic         pkt_valid,
  output logic         crc_ok,
  output logic         crc_err,
  output logic         pid_err,
  output logic         rx_overrun
);

  typedef enum logic [2:0] {IDLE, PID, DATA, CHECK, DONE} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic        overflow;
  logic        fb;
  logic [15:0] lfsr_next;
  logic [99:0] pkt_with_bit;
  logic        has_room;
  logic        pid_bad;
  logic        residual_ok;
  logic        len_ok;
  logic        status_ok;

  assign fb = bit_in ^ lfsr[15];

  // Polynomial x^16 + x^15 + x^2 + 1, shifting toward x15.
  always_comb begin
    lfsr_next     = {lfsr[14:0], fb};
    lfsr_next[2]  = lfsr[1] ^ fb;
    lfsr_next[15] = lfsr[14] ^ fb;
  end

  assign has_room     = (pkt_len < 7'd100);
  assign pkt_with_bit = pkt_out | ({99'd0, bit_in} << pkt_len);
  assign pid_bad      = (pkt_out[7:4] != ~pkt_out[3:0]);
  assign residual_ok  = (lfsr == 16'h800D);
  assign len_ok       = (pkt_len >= 7'd24);
  assign status_ok    = residual_ok & len_ok & ~pid_bad & ~overflow;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pkt_out    <= '0;
      pkt_len    <= '0;
      lfsr       <= '1;
      overflow   <= 1'b0;
      pkt_valid  <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      pid_err    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_start) begin
            pkt_out  <= '0;
            pkt_len  <= '0;
            lfsr     <= '1;
            overflow <= 1'b0;
            state    <= PID;
          end
        end
        PID, DATA: begin
          if (rx_start) begin
            pkt_out  <= '0;
            pkt_len  <= '0;
            lfsr     <= '1;
            overflow <= 1'b0;
            state    <= PID;
          end else if (rx_abort) begin
            state <= IDLE;
          end else begin
            if (bit_valid) begin
              if (has_room) begin
                pkt_out <= pkt_with_bit;
                pkt_len <= pkt_len + 7'd1;
                if (state == DATA) lfsr <= lfsr_next;
              end else begin
                overflow <= 1'b1;
              end
            end
            // A bit arriving with EOP is absorbed before the check.
            if (rx_eop) begin
              state <= CHECK;
            end else if (bit_valid && (state == PID) && (pkt_len == 7'd7)) begin
              state <= DATA;
            end
          end
        end
        CHECK: begin
          if (rx_abort) begin
            state <= IDLE;
          end else begin
            pid_err   <= pid_bad;
            crc_ok    <= status_ok;
            crc_err   <= ~status_ok;
            pkt_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rx_start) rx_overrun <= 1'b1;
          if (ph_ack) begin
            pkt_valid <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            pid_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_rx_check.sv
// Bench for crc16_rx_check: directed vector table, control-event sequences and
// randomized frames checked against a reflected-CRC reference model.
module tb_crc16_rx_check;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_start = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        rx_eop = 1'b0;
  logic        rx_abort = 1'b0;
  logic        ph_ack = 1'b0;
  logic [99:0] pkt_out;
  logic [6:0]  pkt_len;
  logic        pkt_valid, crc_ok, crc_err, pid_err, rx_overrun;

  int checks = 0;
  int errors = 0;

  logic [127:0] stream;
  int           nbits;

  typedef struct {
    string       name;
    logic [7:0]  pid;
    int          nbytes;
    logic [95:0] payload;
    int          flip;
    int          force_bits;
    int          exp_len;
    bit          exp_ok;
    bit          exp_pid;
  } vec_t;

  vec_t vecs [6];

  always #5 clock = ~clock;

  crc16_rx_check dut (
    .clock(clock), .reset_n(reset_n), .rx_start(rx_start), .bit_valid(bit_valid),
    .bit_in(bit_in), .rx_eop(rx_eop), .rx_abort(rx_abort), .ph_ack(ph_ack),
    .pkt_out(pkt_out), .pkt_len(pkt_len), .pkt_valid(pkt_valid), .crc_ok(crc_ok),
    .crc_err(crc_err), .pid_err(pid_err), .rx_overrun(rx_overrun)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC-16/USB in its reflected, LSB-first form over stream[first..last_excl-1].
  function automatic logic [15:0] crc_ref(input int first, input int last_excl);
    logic [15:0] r = 16'hFFFF;
    logic        lsb;
    for (int i = first; i < last_excl; i++) begin
      lsb = r[0] ^ stream[i];
      r   = r >> 1;
      if (lsb) r = r ^ 16'hA001;
    end
    return ~r;
  endfunction

  task automatic build_frame(input logic [7:0] pid, input int nbytes, input logic [95:0] payload);
    logic [15:0] c;
    stream = '0;
    for (int i = 0; i < 8; i++) stream[i] = pid[i];
    for (int i = 0; i < nbytes * 8; i++) stream[8 + i] = payload[i];
    c = crc_ref(8, 8 + nbytes * 8);
    for (int i = 0; i < 16; i++) stream[8 + nbytes * 8 + i] = c[i];
    nbits = 24 + nbytes * 8;
  endtask

  function automatic logic [99:0] exp_pkt();
    logic [99:0] v = '0;
    for (int i = 0; i < 100; i++) if (i < nbits) v[i] = stream[i];
    return v;
  endfunction

  function automatic bit model_pid_err();
    logic [99:0] v = exp_pkt();
    return (v[7:4] != ~v[3:0]);
  endfunction

  function automatic bit model_ok();
    logic [15:0] sent;
    if (nbits < 24 || nbits > 100 || model_pid_err()) return 1'b0;
    for (int i = 0; i < 16; i++) sent[i] = stream[nbits - 16 + i];
    return (crc_ref(8, nbits - 16) == sent);
  endfunction

  task automatic send_bits(input int upto, input bit eop_last);
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    for (int i = 0; i < upto; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      bit_valid = 1'b1;
      bit_in    = stream[i];
      if (eop_last && i == upto - 1) rx_eop = 1'b1;
      tick();
      bit_valid = 1'b0;
      rx_eop    = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input int exp_len, input bit exp_ok, input bit exp_pid);
    bit eop_last = (nbits > 0) && ($urandom_range(0, 1) == 1);
    send_bits(nbits, eop_last);
    if (!eop_last) begin
      rx_eop = 1'b1;
      tick();
      rx_eop = 1'b0;
    end
    check({name, " valid_in_check"}, 100'(pkt_valid), 100'(0));
    tick();
    check({name, " pkt_valid"}, 100'(pkt_valid), 100'(1));
    check({name, " pkt_len"},   100'(pkt_len),   100'(exp_len));
    check({name, " crc_ok"},    100'(crc_ok),    100'(exp_ok));
    check({name, " crc_err"},   100'(crc_err),   100'(!exp_ok));
    check({name, " pid_err"},   100'(pid_err),   100'(exp_pid));
    check({name, " pkt_out"},   pkt_out,         exp_pkt());
  endtask

  task automatic ack_result(input string name);
    ph_ack = 1'b1;
    tick();
    ph_ack = 1'b0;
    check({name, " ack_clears"}, 100'({pkt_valid, crc_ok, crc_err, pid_err}), 100'(0));
  endtask

  initial begin
    vecs[0] = '{"zero_len",  8'hC3, 0, 96'h0,         -1, 0,   24,  1'b1, 1'b0};
    vecs[1] = '{"loopback",  8'h4B, 4, 96'h03020100,  -1, 0,   56,  1'b1, 1'b0};
    vecs[2] = '{"corrupt",   8'h4B, 4, 96'h03020100,  28, 0,   56,  1'b0, 1'b0};
    vecs[3] = '{"bad_pid",   8'hC2, 0, 96'h0,         -1, 0,   24,  1'b0, 1'b1};
    vecs[4] = '{"short",     8'hC3, 0, 96'h0,         -1, 20,  20,  1'b0, 1'b0};
    vecs[5] = '{"long",      8'hC3, 0, 96'h0,         -1, 105, 100, 1'b0, 1'b0};

    repeat (2) tick();
    check("reset outputs", 100'({pkt_valid, crc_ok, crc_err, pid_err, rx_overrun}), 100'(0));
    check("reset pkt_len", 100'(pkt_len), 100'(0));
    check("reset pkt_out", pkt_out, 100'(0));
    reset_n = 1'b1;
    tick();

    // A stray ack in IDLE must be harmless.
    ph_ack = 1'b1;
    tick();
    ph_ack = 1'b0;

    foreach (vecs[k]) begin
      build_frame(vecs[k].pid, vecs[k].nbytes, vecs[k].payload);
      if (vecs[k].flip >= 0) stream[vecs[k].flip] = ~stream[vecs[k].flip];
      if (vecs[k].force_bits > 0) nbits = vecs[k].force_bits;
      run_frame(vecs[k].name, vecs[k].exp_len, vecs[k].exp_ok, vecs[k].exp_pid);
      if (k == 0) check("zero_len pid byte", 100'(pkt_out[7:0]), 100'(8'hC3));
      if (k == 1) check("loopback payload", 100'(pkt_out[39:8]), 100'(32'h03020100));
      ack_result(vecs[k].name);
    end

    // Abort mid-packet: back to IDLE, a later EOP is ignored.
    build_frame(8'h4B, 4, 96'h03020100);
    send_bits(30, 1'b0);
    rx_abort = 1'b1;
    tick();
    rx_abort = 1'b0;
    rx_eop = 1'b1;
    tick();
    rx_eop = 1'b0;
    repeat (3) tick();
    check("abort no pkt_valid", 100'(pkt_valid), 100'(0));

    // Restart mid-packet: run_frame begins with a fresh rx_start.
    build_frame(8'hD2, 3, 96'hA55A3C);
    send_bits(30, 1'b0);
    build_frame(8'h4B, 4, 96'h03020100);
    run_frame("restart", 56, 1'b1, 1'b0);

    // rx_start while a result is held.
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    check("overrun pulse", 100'(rx_overrun), 100'(1));
    check("overrun held", 100'(pkt_valid), 100'(1));
    bit_valid = 1'b1;
    bit_in = 1'b1;
    rx_eop = 1'b1;
    tick();
    bit_valid = 1'b0;
    rx_eop = 1'b0;
    check("overrun one cycle", 100'(rx_overrun), 100'(0));
    check("overrun pkt_out frozen", pkt_out, exp_pkt());
    check("overrun pkt_len frozen", 100'(pkt_len), 100'(56));
    ack_result("overrun");

    // Reset in the middle of a packet.
    build_frame(8'h4B, 4, 96'h03020100);
    send_bits(40, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midreset flags", 100'({pkt_valid, crc_ok, crc_err, pid_err, rx_overrun}), 100'(0));
    check("midreset pkt_len", 100'(pkt_len), 100'(0));
    check("midreset pkt_out", pkt_out, 100'(0));
    tick();
    reset_n = 1'b1;
    tick();
    build_frame(8'hC3, 0, 96'h0);
    run_frame("after_reset", 24, 1'b1, 1'b0);
    ack_result("after_reset");

    // Randomized frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      logic [7:0]  pid;
      logic [3:0]  nib;
      logic [95:0] pl;
      nib = 4'($urandom_range(0, 15));
      pid = ($urandom_range(0, 3) != 0) ? {~nib, nib} : 8'($urandom);
      pl  = {$urandom, $urandom, $urandom};
      build_frame(pid, $urandom_range(0, 11), pl);
      if ($urandom_range(0, 3) == 0) begin
        int f = $urandom_range(0, nbits - 1);
        stream[f] = ~stream[f];
      end
      if ($urandom_range(0, 5) == 0) nbits = $urandom_range(0, nbits);
      run_frame($sformatf("rand%0d", r), (nbits > 100) ? 100 : nbits, model_ok(), model_pid_err());
      ack_result($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
